// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

   localparam int SEQDET_MAX_LEN_LIMIT = 32;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_FILL = 2'd1,
      ST_HUNT = 2'd2
   } seqdet_state_t;

   // Bits needed to hold a pattern length in 0..max_len.
   function automatic int seqdet_len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && !(&q))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with Mealy match pulse.
// Optional saturating match counter built only when SEQDET_MATCH_CNT_EN is defined.
//
//   state   | meaning
//   ST_OFF  | detector disabled, history cleared, no matches
//   ST_FILL | collecting the first len-1 bits after a restart
//   ST_HUNT | history holds len-1 bits, every valid bit is checked
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
   parameter int                 RST_LEN     = 4,
   parameter logic               RST_OVERLAP = 1'b1,
   parameter int                 CNT_W       = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           din,
   input  logic                           din_valid,
   input  logic                           en,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           cnt_clr,
   output logic                           dout,
   output logic                           cfg_err,
   output logic [CNT_W-1:0]               match_count
);

   localparam int LW = seqdet_len_w(MAX_LEN);

   logic [MAX_LEN-1:0] pattern_q;
   logic [LW-1:0]      len_q;
   logic               overlap_q;
   logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift, window, mask;
   logic [LW-1:0]      fill_q, fill_d, fill_inc;
   seqdet_state_t      state_q, state_d;
   logic               cfg_ok, match, dout_c;

   assign cfg_ok     = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
   assign hist_shift = {hist_q[MAX_LEN-2:0], din};
   assign window     = hist_shift;
   assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LW'(1);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len_q));
   end

   assign match = (((window ^ pattern_q) & mask) == '0);

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      dout_c  = 1'b0;
      if (cfg_load) begin
         // a rejected load leaves everything untouched
         if (cfg_ok) begin
            hist_d  = '0;
            fill_d  = '0;
            if (!en)
               state_d = ST_OFF;
            else
               state_d = (cfg_len == LW'(1)) ? ST_HUNT : ST_FILL;
         end
      end else if (!en) begin
         state_d = ST_OFF;
         hist_d  = '0;
         fill_d  = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = (len_q == LW'(1)) ? ST_HUNT : ST_FILL;
            end
            ST_FILL: begin
               if (din_valid) begin
                  hist_d = hist_shift;
                  fill_d = fill_inc;
                  if (fill_inc >= len_q - LW'(1))
                     state_d = ST_HUNT;
               end
            end
            ST_HUNT: begin
               if (din_valid) begin
                  dout_c = match;
                  if (match && !overlap_q) begin
                     hist_d  = '0;
                     fill_d  = '0;
                     state_d = (len_q == LW'(1)) ? ST_HUNT : ST_FILL;
                  end else begin
                     hist_d = hist_shift;
                     fill_d = fill_inc;
                  end
               end
            end
            default: begin
               state_d = ST_OFF;
               hist_d  = '0;
               fill_d  = '0;
            end
         endcase
      end
   end

   assign dout = dout_c & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= RST_PATTERN;
         len_q     <= LW'(RST_LEN);
         overlap_q <= RST_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         state_q   <= ST_OFF;
         cfg_err   <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         cfg_err <= cfg_load & ~cfg_ok;
         if (cfg_load && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
         end
      end
   end

`ifdef SEQDET_MATCH_CNT_EN
   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (dout),
      .clr   (cnt_clr),
      .q     (match_count)
   );
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: expected outputs queued per driven cycle.
module tb_seq_detect_prog;

   localparam int ML = 8;
   localparam int CW = 2;
`ifdef SEQDET_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, din, din_valid, en, cfg_load, cfg_overlap, cnt_clr;
   logic [ML-1:0] cfg_pattern;
   logic [3:0]    cfg_len;
   logic          dout, cfg_err;
   logic [CW-1:0] match_count;

   typedef struct packed {
      logic          d;
      logic          e;
      logic [CW-1:0] c;
   } exp_t;

   exp_t          exp_q[$];
   int            n_cmp  = 0;
   int            n_fail = 0;
   int            n_step = 0;
   logic          err_pend = 1'b0;
   logic [CW-1:0] cnt_m = '0;
   logic [ML-1:0] lp = '0;
   logic [3:0]    ll = '0;
   logic          lo = 1'b0;

   seq_detect_prog #(
      .MAX_LEN(ML), .RST_PATTERN(8'b0000_1011), .RST_LEN(4),
      .RST_OVERLAP(1'b1), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .en(en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .dout(dout),
      .cfg_err(cfg_err), .match_count(match_count)
   );

   always #5 clk = ~clk;

   // One clock cycle: drive at negedge, check 2 ns later, then advance the model.
   task automatic step(input logic b, input logic v, input logic ld,
                       input logic rs, input logic cc, input logic ed);
      exp_t e;
      @(negedge clk);
      din = b; din_valid = v; cfg_load = ld; reset = rs; cnt_clr = cc;
      cfg_pattern = lp; cfg_len = ll; cfg_overlap = lo;
      e.d = ed;
      e.e = err_pend;
      e.c = CNT_EN ? cnt_m : '0;
      exp_q.push_back(e);
      #2;
      e = exp_q.pop_front();
      n_step++;
      n_cmp++;
      assert (dout === e.d) else begin
         n_fail++;
         $error("FAIL dout step %0d observed=%b expected=%b", n_step, dout, e.d);
      end
      n_cmp++;
      assert (cfg_err === e.e) else begin
         n_fail++;
         $error("FAIL cfg_err step %0d observed=%b expected=%b", n_step, cfg_err, e.e);
      end
      n_cmp++;
      assert (match_count === e.c) else begin
         n_fail++;
         $error("FAIL match_count step %0d observed=%0d expected=%0d", n_step, match_count, e.c);
      end
      err_pend = ld && !rs && ((cfg_len == 4'd0) || (cfg_len > 4'(ML)));
      if (rs || cc)
         cnt_m = '0;
      else if (ed && (cnt_m != {CW{1'b1}}))
         cnt_m = cnt_m + 1'b1;
   endtask

   task automatic stream(input logic [15:0] bits, input logic [15:0] expd, input int n);
      for (int i = n - 1; i >= 0; i--)
         step(bits[i], 1'b1, 1'b0, 1'b0, 1'b0, expd[i]);
   endtask

   // Load with din=1 valid=1 so a missing load-cycle gate would show up.
   task automatic load(input logic [ML-1:0] p, input logic [3:0] l, input logic ov);
      lp = p; ll = l; lo = ov;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; din = 1'b0; din_valid = 1'b0; en = 1'b1; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

      // reset holds dout low even with a valid 1 on the input
      step(1, 1, 0, 1, 0, 0);
      step(1, 1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // reset config 1011 overlapping
      stream(16'b1011011, 16'b0001001, 7);

      // non-overlapping 1011
      load(8'b1011, 4'd4, 1'b0);
      stream(16'b1011011, 16'b0001000, 7);
      load(8'b1011, 4'd4, 1'b0);
      stream(16'b10111011, 16'b00010001, 8);
      step(0, 0, 0, 0, 1, 0);

      // pattern 110 with gaps in din_valid; gap carries din=0 while in HUNT
      load(8'b110, 4'd3, 1'b1);
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);

      // rejected loads keep the 1011 config
      load(8'b1011, 4'd4, 1'b1);
      load(8'b0110, 4'd0, 1'b0);
      load(8'b0110, 4'd9, 1'b0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      stream(16'b1011, 16'b0001, 4);

      // reset in the middle of 101 discards the partial match
      stream(16'b101, 16'b000, 3);
      step(1, 1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      stream(16'b1011, 16'b0001, 4);
      step(0, 0, 0, 0, 0, 0);

      // len 1: every valid 1 matches; counter saturates, clear beats increment
      load(8'b1, 4'd1, 1'b1);
      stream(16'b110111, 16'b110111, 6);
      step(1, 1, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
